// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO accumulate unit: accumulate opcodes, FSM states, opcode decode helpers.
package hilo_pkg;

  typedef enum logic [1:0] {
    ACC_MADDU = 2'b00,
    ACC_MADD  = 2'b01,
    ACC_MSUBU = 2'b10,
    ACC_MSUB  = 2'b11
  } acc_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    ACC  = 2'b10
  } state_e;

  function automatic logic op_is_signed(acc_op_e op);
    return (op == ACC_MADD) || (op == ACC_MSUB);
  endfunction

  function automatic logic op_is_sub(acc_op_e op);
    return (op == ACC_MSUBU) || (op == ACC_MSUB);
  endfunction

endpackage

// File: rtl/hilo_acc_unit_if.sv
// Request/result bundle between the pipeline (master) and the HI/LO unit (slave).
interface hilo_acc_unit_if #(parameter int unsigned DW = 32) ();

  logic          wr_hi_en;
  logic          wr_lo_en;
  logic [DW-1:0] wr_hi;
  logic [DW-1:0] wr_lo;
  logic          acc_valid;
  logic          acc_ready;
  logic [1:0]    acc_op;
  logic [DW-1:0] acc_a;
  logic [DW-1:0] acc_b;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic [DW-1:0] hi_rd;
  logic [DW-1:0] lo_rd;
  logic          busy;
  logic          done;
  logic          wr_err;

  modport master (
    output wr_hi_en, wr_lo_en, wr_hi, wr_lo, acc_valid, acc_op, acc_a, acc_b,
    input  acc_ready, hi_o, lo_o, hi_rd, lo_rd, busy, done, wr_err
  );

  modport slave (
    input  wr_hi_en, wr_lo_en, wr_hi, wr_lo, acc_valid, acc_op, acc_a, acc_b,
    output acc_ready, hi_o, lo_o, hi_rd, lo_rd, busy, done, wr_err
  );

endinterface

// File: rtl/hilo_mul.sv
// Registered DW x DW multiplier, signed or unsigned, full 2*DW-bit product.
module hilo_mul #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sgn,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] p
);

  localparam int unsigned PW = 2 * DW;

  logic [PW-1:0] a_ext_c;
  logic [PW-1:0] b_ext_c;

  // Extending to the full product width makes the low 2*DW bits of the product exact for both signednesses.
  always_comb begin
    a_ext_c = sgn ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    b_ext_c = sgn ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= PW'(a_ext_c * b_ext_c);
    end
  end

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO architectural registers with direct writes, a 3-cycle multiply-accumulate sequence
// and an optional same-cycle write bypass on the MFHI/MFLO read port.
module hilo_acc_unit
  import hilo_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter bit          BYPASS = 1'b1
) (
  input logic          clk,
  input logic          rst,
  hilo_acc_unit_if.slave bus
);

  localparam int unsigned AW = 2 * DW;

  state_e        state;
  state_e        state_nxt;
  acc_op_e       op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;
  logic          done_q;
  logic          wr_err_q;
  logic [AW-1:0] prod;
  logic [AW-1:0] acc_sum_c;
  logic          accept_c;
  logic          wr_any_c;
  logic          mul_en_c;
  logic          mul_sgn_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    mul_en_c  = 1'b0;
    case (state)
      IDLE: begin
        accept_c = bus.acc_valid;
        if (bus.acc_valid) state_nxt = MUL;
      end
      MUL: begin
        mul_en_c  = 1'b1;
        state_nxt = ACC;
      end
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_any_c  = bus.wr_hi_en | bus.wr_lo_en;
  assign mul_sgn_c = op_is_signed(op_q);

  hilo_mul #(.DW(DW)) u_mul (
    .clk (clk),
    .rst (rst),
    .en  (mul_en_c),
    .sgn (mul_sgn_c),
    .a   (a_q),
    .b   (b_q),
    .p   (prod)
  );

  // HI/LO already hold any write accepted alongside the request by the time ACC reads them.
  assign acc_sum_c = op_is_sub(op_q) ? AW'({hi_q, lo_q} - prod) : AW'({hi_q, lo_q} + prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= ACC_MADDU;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      done_q   <= (state == ACC);
      wr_err_q <= (state != IDLE) && wr_any_c;
      if (accept_c) begin
        op_q <= acc_op_e'(bus.acc_op);
        a_q  <= bus.acc_a;
        b_q  <= bus.acc_b;
      end
      if (state == IDLE) begin
        if (bus.wr_hi_en) hi_q <= bus.wr_hi;
        if (bus.wr_lo_en) lo_q <= bus.wr_lo;
      end else if (state == ACC) begin
        {hi_q, lo_q} <= acc_sum_c;
      end
    end
  end

  // Writes are only forwarded in IDLE; while busy the pipeline is stalled and reads are stale.
  always_comb begin
    bus.hi_rd = hi_q;
    bus.lo_rd = lo_q;
    if (BYPASS && (state == IDLE)) begin
      if (bus.wr_hi_en) bus.hi_rd = bus.wr_hi;
      if (bus.wr_lo_en) bus.lo_rd = bus.wr_lo;
    end
  end

  assign bus.acc_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
  assign bus.done      = done_q;
  assign bus.wr_err    = wr_err_q;

endmodule

// File: doc/hilo_acc_unit.md
# hilo_acc_unit

Parametrised HI/LO register unit for the execute/writeback boundary of the MIPS pipeline. It holds the HI and LO architectural registers, accepts direct writes (MTHI/MTLO, MULT/DIV results) with independent half enables, and performs multiply-accumulate operations (MADD/MADDU/MSUB/MSUBU) as a two-stage sequenced operation with a ready/valid handshake. Optional same-cycle write bypass feeds the read port used by MFHI/MFLO.

## Interface

Parameters:
- DW, 32: width of each of HI and LO. The accumulator is 2*DW.
- BYPASS, 1: when 1, hi_rd/lo_rd forward an accepted same-cycle direct write. When 0, they equal hi_o/lo_o.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_hi_en  in  1  direct write enable for HI.
- wr_lo_en  in  1  direct write enable for LO.
- wr_hi  in  DW  HI write data.
- wr_lo  in  DW  LO write data.
- acc_valid  in  1  accumulate request.
- acc_ready  out  1  unit is IDLE and can accept a request.
- acc_op  in  2  00 MADDU, 01 MADD, 10 MSUBU, 11 MSUB.
- acc_a, acc_b  in  DW  multiplicands.
- hi_o, lo_o  out  DW  registered architectural HI/LO.
- hi_rd, lo_rd  out  DW  read port, bypassed per BYPASS.
- busy  out  1  equal to !acc_ready.
- done  out  1  one-cycle pulse in the cycle the accumulate result first appears on hi_o/lo_o.
- wr_err  out  1  one-cycle pulse, registered: a direct write was attempted while busy.

## Operation

- States: IDLE, MUL, ACC.
  - IDLE -> MUL on acc_valid && acc_ready. acc_op, acc_a and acc_b are latched.
  - MUL -> ACC unconditionally. The registered 2*DW product is captured.
  - ACC -> IDLE unconditionally. {hi,lo} <= {hi,lo} ± product.
- Product arithmetic:
  - Signed ops (op[0]=1) use a two's-complement DW x DW product.
  - Unsigned ops zero-extend the operands.
  - The result is always 2*DW bits.
- Accumulate arithmetic is modulo 2^(2*DW). Overflow wraps silently, with no flag.
- Direct writes are accepted only in IDLE. Each half updates independently per its enable.
- Direct write while busy:
  - The write is ignored and HI/LO are unchanged.
  - wr_err pulses the following cycle.
- Direct write and acc_valid in the same IDLE cycle:
  - Both are accepted.
  - The write lands at that edge, and the accumulate uses the newly written values.
- Reset values:
  - hi_o=0, lo_o=0, state IDLE.
  - acc_ready=1, busy=0, done=0, wr_err=0.
- Reset mid-operation aborts the operation. HI/LO go to 0 and no done pulse is issued.
- Read port bypass:
  - With BYPASS=1 in IDLE: hi_rd = wr_hi_en ? wr_hi : hi_o. lo_rd works the same way.
  - While busy: hi_rd/lo_rd = hi_o/lo_o. Stale data is expected here; the pipeline stalls on busy.

## Timing

- Request accepted at the edge ending cycle T:
  - Cycle T+1 is MUL.
  - Cycle T+2 is ACC.
  - The result appears on hi_o/lo_o, done=1 and acc_ready=1 in cycle T+3.
- Throughput is one accumulate per 3 cycles. A new request may be accepted in cycle T+3.
- A direct write accepted at edge E is visible on hi_o/lo_o in the cycle after E. With BYPASS=1 it is visible on hi_rd/lo_rd combinationally in the same cycle.
- acc_ready and busy depend only on state (registered), with no combinational path from inputs.
- done and wr_err are registered single-cycle pulses.

## Structure

- Shared package hilo_pkg:
  - acc_op encodings: ACC_MADDU, ACC_MADD, ACC_MSUBU, ACC_MSUB.
  - State enum: IDLE, MUL, ACC.
- Sub-module hilo_mul: DW x DW registered multiplier with a signed/unsigned select, producing a 2*DW output. It is instantiated once and occupies the MUL stage.
- The top level holds the FSM, the HI/LO registers, the accumulate adder/subtractor and the bypass mux.

## Test plan

- Reset, then wr_hi_en=wr_lo_en=1 with hi=0x12345678, lo=0x9ABCDEF0 -> hi_rd/lo_rd show the values the same cycle and hi_o/lo_o the next. Reset mid-stream -> both 0.
- MADDU with hi=0, lo=0xFFFFFFFF, a=2, b=3 -> exactly 3 cycles later {hi,lo}=0x00000001_00000005, done pulses once, and acc_ready is low for 2 cycles.
- MSUB with hi=lo=0, a=-1 (0xFFFFFFFF), b=1 -> {hi,lo}=0x00000000_00000001. MSUBU with the same inputs -> {hi,lo}=0xFFFFFFFF_00000001 (wrap).
- Direct write of hi=0xDEAD in cycle T+1 of an accumulate -> the write is ignored, wr_err pulses in T+2, and the accumulate result is unaffected.
- wr_lo_en=1 with lo=5 plus a MADDU with a=1, b=1 in the same IDLE cycle, starting from hi=lo=0 -> final {hi,lo}=0x0_00000006.
- With BYPASS=0 and a direct write -> hi_rd follows hi_o with one-cycle latency. Also: reset asserted in the ACC cycle -> no done pulse and outputs 0.
